// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC / instruction fetch sequencer.
//  - fetch_state_e : sequencer FSM states (idle, fetch outstanding, instruction held)
//  - Def*          : default parameter values for pc_fetch_sequencer
package pc_fetch_pkg;

  localparam int unsigned DefAddrW   = 16;
  localparam int unsigned DefInstrW  = 32;
  localparam logic [15:0] DefResetPc = 16'h0000;
  localparam int unsigned DefInc     = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer for the single-cycle core.
//
// Ports:
//  clk, rst_n      clock (rising edge), asynchronous active-low reset
//  branch_taken    1-cycle redirect pulse from execute
//  pc_src          PC mux select (1 = branch target), equal to branch_taken
//  pc_inc          pc + INC, feeds mux input a
//  next_pc         PC mux output, loaded into pc on branch or accepted fetch
//  imem_req/addr   fetch request and address (address held until imem_ack)
//  imem_ack/rdata  fetch completion and returned instruction
//  instr_valid/ready, instr_out, instr_pc
//                  valid/ready handoff of the held instruction to decode
//  pc              architectural PC (next address to fetch)
//
// The PC-source mux is external; this block only drives its select and input a.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter int unsigned       INSTR_W  = DefInstrW,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc),
  parameter int unsigned       INC      = DefInc
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_taken,
  output logic               pc_src,
  output logic [ADDR_W-1:0]  pc_inc,
  input  logic [ADDR_W-1:0]  next_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               squash_q, squash_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      squash_q <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    squash_d = squash_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;

    // A branch redirects the PC regardless of where the fetch FSM is.
    if (branch_taken) begin
      pc_d = next_pc;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        addr_d  = branch_taken ? next_pc : pc_q;
      end

      StFetch: begin
        if (imem_ack) begin
          if (squash_q || branch_taken) begin
            // Stale data: drop it and reissue immediately from the redirected PC.
            squash_d = 1'b0;
            addr_d   = branch_taken ? next_pc : pc_q;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            pc_d    = next_pc;  // mux selects pc_inc when no branch
            state_d = StHold;
          end
        end else if (branch_taken) begin
          // Address must stay stable until ack, so remember to discard the response.
          squash_d = 1'b1;
        end
      end

      StHold: begin
        if (branch_taken) begin
          valid_d = 1'b0;
          addr_d  = next_pc;
          state_d = StFetch;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          addr_d  = pc_q;
          state_d = StFetch;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign pc_src      = branch_taken;
  assign pc_inc      = pc_q + ADDR_W'(INC);
  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign pc          = pc_q;

endmodule
